// File: rtl/ball_pkg.sv
// ============================================================================
// Module   : ball_pkg
// Purpose  : Shared FSM state type, keycode constants and position width for
//            the ball motion controller.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package ball_pkg;

    localparam int POS_W = 10;

    typedef enum logic [1:0] {
        S_WAIT   = 2'd0,
        S_MOTION = 2'd1,
        S_MOVE   = 2'd2
    } state_t;

    localparam logic [7:0] KEY_W     = 8'h1A;
    localparam logic [7:0] KEY_A     = 8'h04;
    localparam logic [7:0] KEY_S     = 8'h16;
    localparam logic [7:0] KEY_D     = 8'h07;
    localparam logic [7:0] KEY_SPACE = 8'h2C;

endpackage

`default_nettype wire

// File: rtl/sync_rise_det.sv
// ============================================================================
// Module   : sync_rise_det
// Purpose  : Two-flop synchroniser followed by a one-cycle rising-edge pulse.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_rise_det (
    input  logic Clk,
    input  logic Reset,
    input  logic d,
    output logic pulse
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign pulse = r_sync & ~r_prev;

endmodule

`default_nettype wire

// File: rtl/ball_motion_controller.sv
// ============================================================================
// Module   : ball_motion_controller
// Purpose  : Once per frame, resolves wall bounces and key input into motion,
//            then advances and clamps the ball position.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ball_motion_controller
    import ball_pkg::*;
#(
    parameter int X_MIN    = 0,
    parameter int X_MAX    = 639,
    parameter int Y_MIN    = 0,
    parameter int Y_MAX    = 479,
    parameter int X_CENTER = 320,
    parameter int Y_CENTER = 240,
    parameter int STEP     = 1,
    parameter int SIZE     = 4
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             frame_clk,
    input  logic [7:0]       keycode,
    output logic [POS_W-1:0] BallX,
    output logic [POS_W-1:0] BallY,
    output logic [POS_W-1:0] BallS,
    output logic             busy
);

    localparam logic signed [POS_W-1:0] c_step_pos = POS_W'(STEP);
    localparam logic signed [POS_W-1:0] c_step_neg = -c_step_pos;
    localparam logic signed [POS_W:0]   c_x_lo     = (POS_W+1)'(X_MIN + SIZE);
    localparam logic signed [POS_W:0]   c_x_hi     = (POS_W+1)'(X_MAX - SIZE);
    localparam logic signed [POS_W:0]   c_y_lo     = (POS_W+1)'(Y_MIN + SIZE);
    localparam logic signed [POS_W:0]   c_y_hi     = (POS_W+1)'(Y_MAX - SIZE);

    state_t                   r_state;
    state_t                   w_state_next;
    logic                     w_tick;
    logic signed [POS_W-1:0]  r_motion_x;
    logic signed [POS_W-1:0]  r_motion_y;
    logic signed [POS_W-1:0]  w_motion_x_next;
    logic signed [POS_W-1:0]  w_motion_y_next;
    logic [POS_W-1:0]         r_ball_x;
    logic [POS_W-1:0]         r_ball_y;
    logic signed [POS_W:0]    w_sum_x;
    logic signed [POS_W:0]    w_sum_y;
    logic signed [POS_W:0]    w_clamp_x;
    logic signed [POS_W:0]    w_clamp_y;
    logic                     r_paused;
    logic                     r_space_prev;
    logic                     w_space;

    sync_rise_det u_frame_sync (
        .Clk   (Clk),
        .Reset (Reset),
        .d     (frame_clk),
        .pulse (w_tick)
    );

    always_ff @(posedge Clk) begin
        if (Reset) r_state <= S_WAIT;
        else       r_state <= w_state_next;
    end

    // Ticks arriving outside S_WAIT are simply ignored.
    always_comb begin
        w_state_next = r_state;
        busy         = 1'b0;
        case (r_state)
            S_WAIT:   if (w_tick) w_state_next = S_MOTION;
            S_MOTION: begin
                busy         = 1'b1;
                w_state_next = S_MOVE;
            end
            S_MOVE:   begin
                busy         = 1'b1;
                w_state_next = S_WAIT;
            end
            default:  w_state_next = S_WAIT;
        endcase
    end

    // Bounce has priority per axis; keys only steer an axis not at a wall.
    always_comb begin
        w_motion_x_next = r_motion_x;
        w_motion_y_next = r_motion_y;
        if (({1'b0, r_ball_x} + (POS_W+1)'(SIZE)) >= (POS_W+1)'(X_MAX))
            w_motion_x_next = c_step_neg;
        else if ({1'b0, r_ball_x} <= (POS_W+1)'(X_MIN + SIZE))
            w_motion_x_next = c_step_pos;
        else if (keycode == KEY_W || keycode == KEY_S)
            w_motion_x_next = '0;
        else if (keycode == KEY_A)
            w_motion_x_next = c_step_neg;
        else if (keycode == KEY_D)
            w_motion_x_next = c_step_pos;

        if (({1'b0, r_ball_y} + (POS_W+1)'(SIZE)) >= (POS_W+1)'(Y_MAX))
            w_motion_y_next = c_step_neg;
        else if ({1'b0, r_ball_y} <= (POS_W+1)'(Y_MIN + SIZE))
            w_motion_y_next = c_step_pos;
        else if (keycode == KEY_A || keycode == KEY_D)
            w_motion_y_next = '0;
        else if (keycode == KEY_W)
            w_motion_y_next = c_step_neg;
        else if (keycode == KEY_S)
            w_motion_y_next = c_step_pos;
    end

    always_comb begin
        w_sum_x = $signed({1'b0, r_ball_x}) + $signed({r_motion_x[POS_W-1], r_motion_x});
        w_sum_y = $signed({1'b0, r_ball_y}) + $signed({r_motion_y[POS_W-1], r_motion_y});
        w_clamp_x = w_sum_x;
        w_clamp_y = w_sum_y;
        if (w_sum_x < c_x_lo) w_clamp_x = c_x_lo;
        if (w_sum_x > c_x_hi) w_clamp_x = c_x_hi;
        if (w_sum_y < c_y_lo) w_clamp_y = c_y_lo;
        if (w_sum_y > c_y_hi) w_clamp_y = c_y_hi;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_motion_x <= '0;
            r_motion_y <= '0;
            r_ball_x   <= POS_W'(X_CENTER);
            r_ball_y   <= POS_W'(Y_CENTER);
        end else begin
            if (r_state == S_MOTION) begin
                r_motion_x <= w_motion_x_next;
                r_motion_y <= w_motion_y_next;
            end
            if (r_state == S_MOVE && !r_paused) begin
                r_ball_x <= w_clamp_x[POS_W-1:0];
                r_ball_y <= w_clamp_y[POS_W-1:0];
            end
        end
    end

    assign w_space = (keycode == KEY_SPACE);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_paused     <= 1'b0;
            r_space_prev <= 1'b0;
        end else begin
            r_space_prev <= w_space;
            if (w_space && !r_space_prev) r_paused <= ~r_paused;
        end
    end

    assign BallX = r_ball_x;
    assign BallY = r_ball_y;
    assign BallS = POS_W'(SIZE);

endmodule

`default_nettype wire

// File: tb/tb_ball_motion_controller.sv
// ============================================================================
// Module   : tb_ball_motion_controller
// Purpose  : Directed self-checking bench for ball_motion_controller.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ball_motion_controller;

    logic       clk;
    logic       Reset;
    logic       frame_clk;
    logic [7:0] keycode;
    logic [9:0] BallX;
    logic [9:0] BallY;
    logic [9:0] BallS;
    logic       busy;

    int n_checks = 0;
    int n_errors = 0;

    ball_motion_controller dut (
        .Clk       (clk),
        .Reset     (Reset),
        .frame_clk (frame_clk),
        .keycode   (keycode),
        .BallX     (BallX),
        .BallY     (BallY),
        .BallS     (BallS),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, actual, expected);
        end
    endtask

    // One vsync pulse; returns how many sampled cycles busy was high.
    task automatic frame(output int busy_cyc);
        busy_cyc  = 0;
        frame_clk = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (busy) busy_cyc++;
        end
        frame_clk = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (busy) busy_cyc++;
        end
    endtask

    initial begin
        int bc;
        int k;
        Reset     = 1'b1;
        frame_clk = 1'b0;
        keycode   = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_x", BallX, 320);
        check("rst_y", BallY, 240);
        check("rst_s", BallS, 4);
        check("rst_busy", busy, 0);
        Reset = 1'b0;
        @(negedge clk);

        // Idle frames: ball stays centred, busy is two cycles per frame
        for (int i = 0; i < 5; i++) begin
            frame(bc);
            check("idle_x", BallX, 320);
            check("idle_y", BallY, 240);
            check("idle_busy", bc, 2);
        end

        // Hold D: one pixel right per frame
        keycode = 8'h07;
        for (int i = 1; i <= 3; i++) begin
            frame(bc);
            check("right_x", BallX, 32'(320 + i));
            check("right_y", BallY, 240);
        end

        // Pause with space held over ten frames
        keycode = 8'h2C;
        for (int i = 0; i < 10; i++) begin
            frame(bc);
            check("pause_x", BallX, 323);
        end
        keycode = 8'h07;
        for (int i = 0; i < 2; i++) begin
            frame(bc);
            check("pause_rel_x", BallX, 323);
        end
        keycode = 8'h2C;
        repeat (2) @(negedge clk);
        keycode = 8'h07;
        @(negedge clk);
        frame(bc);
        check("resume_x1", BallX, 324);
        frame(bc);
        check("resume_x2", BallX, 325);

        // Two vsync edges two cycles apart yield a single update
        frame_clk = 1'b1;
        @(negedge clk);
        frame_clk = 1'b0;
        @(negedge clk);
        frame(bc);
        check("dbl_x", BallX, 326);
        check("dbl_busy", bc, 2);

        // March to the right wall
        for (int i = 0; i < 308; i++) frame(bc);
        check("wall_pre_x", BallX, 634);
        check("wall_pre_y", BallY, 240);
        frame(bc);
        check("wall_x1", BallX, 635);
        frame(bc);
        check("wall_x2", BallX, 634);
        frame(bc);
        check("wall_x3", BallX, 635);

        // March up to the top wall
        keycode = 8'h1A;
        for (int i = 0; i < 234; i++) frame(bc);
        check("top_pre_y", BallY, 6);
        check("top_pre_x", BallX, 634);
        frame(bc);
        check("top_y1", BallY, 5);
        frame(bc);
        check("top_y2", BallY, 4);
        frame(bc);
        check("top_y3", BallY, 5);
        frame(bc);
        check("top_y4", BallY, 4);

        // Reset during S_MOTION aborts the update
        frame_clk = 1'b1;
        k = 0;
        while (!busy && k < 10) begin
            @(negedge clk);
            k++;
        end
        check("abort_busy_seen", busy, 1);
        Reset     = 1'b1;
        frame_clk = 1'b0;
        @(negedge clk);
        check("abort_x", BallX, 320);
        check("abort_y", BallY, 240);
        check("abort_busy", busy, 0);
        Reset = 1'b0;
        repeat (8) @(negedge clk);
        check("abort_hold_x", BallX, 320);
        check("abort_hold_y", BallY, 240);
        check("abort_s", BallS, 4);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule

`default_nettype wire
